// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared memory mask type, arbiter state encoding and beat counter helper
package mem_arbiter_pkg;
  typedef logic [3:0] memory_mask_t;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return v == 8'hFF ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: two-requester memory bus; master is the requester side, slave the arbiter
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;
  logic [1:0] req_i;
  logic [1:0] lock_i;
  logic [1:0] we_i;
  logic [1:0][31:0] addr_i;
  logic [1:0][31:0] wdata_i;
  memory_mask_t [1:0] mask_i;
  logic [1:0] gnt_o;
  logic [31:0] rdata_o;
  modport master(output req_i, lock_i, we_i, addr_i, wdata_i, mask_i, input gnt_o, rdata_o);
  modport slave(input req_i, lock_i, we_i, addr_i, wdata_i, mask_i, output gnt_o, rdata_o);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port RAM arbiter with beat-bounded locked bursts and zero-latency grant
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus,
  output logic [31:0]  ram_a,
  output logic [31:0]  ram_wd,
  output memory_mask_t ram_mask,
  output logic         ram_we,
  input  logic [31:0]  ram_rd
);
  localparam logic [7:0] MAX_B = 8'(MAX_BURST);
  arb_state_t state_q, state_d;
  logic last_q, last_d;
  logic [7:0] beats_q, beats_d, beats_n;
  logic own, owner, win, g, any, other, forced, keep;
  always_comb begin
    own     = state_q != IDLE;
    owner   = state_q == OWN1;
    win     = &bus.req_i ? ~last_q : bus.req_i[1];
    g       = own ? owner : win;
    any     = rst_n & (own ? bus.req_i[owner] : |bus.req_i);
    other   = bus.req_i[~g];
    // a fresh lock counts its first beat; later beats only count while the other side waits
    beats_n = own ? (other ? sat_inc(beats_q) : beats_q) : 8'd1;
    forced  = other & (beats_n >= MAX_B);
    keep    = any & bus.lock_i[g] & ~forced;
    state_d = keep ? (g ? OWN1 : OWN0) : IDLE;
    last_d  = any ? g : last_q;
    beats_d = keep ? beats_n : 8'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      beats_q <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      beats_q <= beats_d;
    end
  end
  assign bus.gnt_o   = any ? (g ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rdata_o = ram_rd;
  assign ram_a       = any ? bus.addr_i[g] : '0;
  assign ram_wd      = any ? bus.wdata_i[g] : '0;
  assign ram_mask    = any ? bus.mask_i[g] : bus.mask_i[0];
  assign ram_we      = any & bus.we_i[g];
endmodule
